// File: rtl/uart_boot_loader_pkg.sv
// Shared constants, state encoding and lane helpers for the boot-memory stream loader.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package uart_boot_loader_pkg;

  localparam logic [7:0] CH_AT    = 8'h40;
  localparam logic [7:0] CH_SLASH = 8'h2F;
  localparam logic [7:0] CH_BANG  = 8'h21;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_TAB   = 8'h09;

  typedef enum logic [2:0] {
    ST_LSTART,
    ST_SLASH,
    ST_SKIP,
    ST_ADDR,
    ST_SEP,
    ST_DATA,
    ST_WRITE,
    ST_DONE
  } state_e;

  // Byte-address bit where the memory word index starts.
  function automatic int unsigned addr_lsb(input int unsigned dw);
    return (dw == 128) ? 4 : 2;
  endfunction

  // Byte enables for one 32-bit word; a 128-bit memory gets one 4-byte lane.
  function automatic logic [15:0] lane_be(input int unsigned dw, input logic [1:0] lane);
    if (dw == 128) begin
      return 16'h000F << {lane, 2'b00};
    end
    return 16'h000F;
  endfunction

  // The 32-bit word is replicated into every lane; byte enables pick the real one.
  function automatic logic [127:0] lane_data(input logic [31:0] w);
    return {4{w}};
  endfunction

endpackage

// File: rtl/uart_boot_loader_hex_nibble.sv
// Classifies an ASCII byte as a hex digit (either case) and yields its 4-bit value.
// Latency: combinational.
// Backpressure: none.
module boot_hex_nibble (
  input  logic [7:0] i_chr,
  output logic       o_is_hex,
  output logic [3:0] o_nibble
);

  logic is_dig;
  logic is_alpha;

  // Letters a-f / A-F share low nibble 1..6, so adding 9 gives 10..15.
  always_comb begin
    is_dig   = (i_chr >= 8'h30) && (i_chr <= 8'h39);
    is_alpha = ((i_chr >= 8'h41) && (i_chr <= 8'h46)) ||
               ((i_chr >= 8'h61) && (i_chr <= 8'h66));
    o_is_hex = is_dig || is_alpha;
    o_nibble = is_alpha ? (i_chr[3:0] + 4'd9) : i_chr[3:0];
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Parses an ASCII boot .mem stream (@AAAAAAAA DDDDDDDD, // comments, ! end marker) into memory word writes.
// Latency: o_wr_valid rises the cycle after the byte terminating the data field is accepted.
// Backpressure: o_byte_ready drops while a write waits on i_wr_ready; BOOT_LOADER_CHECKSUM_EN adds o_checksum.
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int MEM_DW = 32,
  parameter int MEM_AW = 11,
  parameter int CNT_W  = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [7:0]          i_byte,
  input  logic                i_byte_valid,
  output logic                o_byte_ready,
  output logic                o_wr_valid,
  input  logic                i_wr_ready,
  output logic [MEM_AW-1:0]   o_wr_addr,
  output logic [MEM_DW-1:0]   o_wr_data,
  output logic [MEM_DW/8-1:0] o_wr_be,
  output logic [CNT_W-1:0]    o_line_cnt,
  output logic [CNT_W-1:0]    o_word_cnt,
  output logic [CNT_W-1:0]    o_err_cnt,
  output logic                o_done,
  output logic [31:0]         o_checksum
);

  localparam int LSB = addr_lsb(MEM_DW);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic             lf_q, lf_d;
  logic [CNT_W-1:0] line_q, line_d;
  logic [CNT_W-1:0] word_q, word_d;
  logic [CNT_W-1:0] err_q, err_d;

  logic       is_hex;
  logic [3:0] nib;
  logic       is_lf, is_ws, is_cr, is_term;
  logic       take, wr_fire, err_hit;
  logic [15:0]  be_full;
  logic [127:0] data_full;
  logic         unused_bits;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  boot_hex_nibble u_hex (
    .i_chr    (i_byte),
    .o_is_hex (is_hex),
    .o_nibble (nib)
  );

  assign is_lf   = (i_byte == CH_LF);
  assign is_cr   = (i_byte == CH_CR);
  assign is_ws   = (i_byte == CH_SP) || (i_byte == CH_TAB);
  assign is_term = is_ws || is_cr || is_lf || (i_byte == CH_SLASH);
  assign take    = i_byte_valid && o_byte_ready;
  assign wr_fire = (state_q == ST_WRITE) && i_wr_ready;

  // Line parser: one accepted byte per cycle, plus write completion and the shared error path.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    lf_d    = lf_q;
    line_d  = line_q;
    word_d  = word_q;
    err_d   = err_q;
    err_hit = 1'b0;
    if (take) begin
      case (state_q)
        ST_LSTART: begin
          if (i_byte == CH_AT) begin
            state_d = ST_ADDR;
            cnt_d   = '0;
            addr_d  = '0;
          end else if (is_lf) begin
            line_d = sat_inc(line_q);
          end else if (i_byte == CH_SLASH) begin
            state_d = ST_SLASH;
          end else if (i_byte == CH_BANG) begin
            state_d = ST_DONE;
          end else if (!(is_ws || is_cr)) begin
            err_hit = 1'b1;
          end
        end
        ST_SLASH: begin
          if (i_byte == CH_SLASH) state_d = ST_SKIP;
          else                    err_hit = 1'b1;
        end
        ST_SKIP: begin
          if (is_lf) begin
            state_d = ST_LSTART;
            line_d  = sat_inc(line_q);
          end
        end
        ST_ADDR: begin
          if (is_hex && (cnt_q < 4'd8)) begin
            addr_d = {addr_q[27:0], nib};
            cnt_d  = cnt_q + 4'd1;
          end else if (is_ws && (cnt_q == 4'd8)) begin
            // Misaligned byte addresses are rejected before any data is parsed.
            if (addr_q[1:0] != 2'b00) begin
              err_hit = 1'b1;
            end else begin
              state_d = ST_SEP;
              cnt_d   = '0;
            end
          end else begin
            err_hit = 1'b1;
          end
        end
        ST_SEP: begin
          if (is_hex) begin
            state_d = ST_DATA;
            data_d  = {28'h0, nib};
            cnt_d   = 4'd1;
          end else if (!is_ws) begin
            err_hit = 1'b1;
          end
        end
        ST_DATA: begin
          if (is_hex && (cnt_q < 4'd8)) begin
            data_d = {data_q[27:0], nib};
            cnt_d  = cnt_q + 4'd1;
          end else if (is_term && (cnt_q == 4'd8)) begin
            state_d = ST_WRITE;
            lf_d    = is_lf;
          end else begin
            err_hit = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
    if (wr_fire) begin
      word_d = sat_inc(word_q);
      if (lf_q) begin
        state_d = ST_LSTART;
        line_d  = sat_inc(line_q);
      end else begin
        state_d = ST_SKIP;
      end
    end
    // An offending LF also closes the line, otherwise the rest of the line is discarded.
    if (err_hit) begin
      err_d = sat_inc(err_q);
      if (is_lf) begin
        state_d = ST_LSTART;
        line_d  = sat_inc(line_q);
      end else begin
        state_d = ST_SKIP;
      end
    end
  end

  // State and accumulator registers; reset drops any pending write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_LSTART;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      lf_q    <= 1'b0;
      line_q  <= '0;
      word_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      lf_q    <= lf_d;
      line_q  <= line_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  // Running mod-2^32 sum of every data word that completed its handshake.
  always_comb begin
    csum_d = csum_q;
    if (wr_fire) csum_d = csum_q + data_q;
  end

  // Checksum register.
  always_ff @(posedge i_clk) begin
    if (i_rst) csum_q <= '0;
    else       csum_q <= csum_d;
  end

  assign o_checksum = csum_q;
`else
  assign o_checksum = 32'h0;
`endif

  assign be_full   = lane_be(MEM_DW, addr_q[3:2]);
  assign data_full = lane_data(data_q);

  // Payload is zero outside a write so idle outputs read as zero.
  assign o_byte_ready = (state_q != ST_WRITE);
  assign o_wr_valid   = (state_q == ST_WRITE);
  assign o_wr_addr    = o_wr_valid ? addr_q[MEM_AW+LSB-1:LSB] : '0;
  assign o_wr_data    = o_wr_valid ? data_full[MEM_DW-1:0] : '0;
  assign o_wr_be      = o_wr_valid ? be_full[MEM_DW/8-1:0] : '0;
  assign o_line_cnt   = line_q;
  assign o_word_cnt   = word_q;
  assign o_err_cnt    = err_q;
  assign o_done       = (state_q == ST_DONE);

  // Address bits above the index and the replicas unused at this width are dropped on purpose.
  assign unused_bits = ^{addr_q, be_full, data_full};

endmodule

// File: tb/tb_uart_boot_loader.sv
module tb_uart_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_d = 8'h0;
  logic        byte_vld = 1'b0;
  logic        force_rdy = 1'b1;
  logic        rnd_rdy = 1'b1;
  logic        rnd_mode = 1'b0;
  logic        mon_en = 1'b0;
  logic        wr_rdy;

  logic        rdy32, wv32, dn32;
  logic [10:0] wa32;
  logic [31:0] wd32, ck32;
  logic [3:0]  be32;
  logic [15:0] lc32, wc32, ec32;

  logic         rdy128, wv128, dn128;
  logic [10:0]  wa128;
  logic [127:0] wd128;
  logic [31:0]  ck128;
  logic [15:0]  be128, lc128, wc128, ec128;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t q32[$];
  wr_t q128[$];

  typedef struct {
    string       txt;
    int          words;
    int          lines;
    int          errs;
    bit          done;
    logic [31:0] ck;
  } vec_t;
  vec_t vecs[12];

  assign wr_rdy = rnd_mode ? rnd_rdy : force_rdy;

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #1;
    rnd_rdy = ($urandom_range(0, 2) != 0);
  end

  uart_boot_loader #(.MEM_DW(32), .MEM_AW(11), .CNT_W(16)) u32 (
    .i_clk(clk), .i_rst(rst), .i_byte(byte_d), .i_byte_valid(byte_vld),
    .o_byte_ready(rdy32), .o_wr_valid(wv32), .i_wr_ready(wr_rdy),
    .o_wr_addr(wa32), .o_wr_data(wd32), .o_wr_be(be32),
    .o_line_cnt(lc32), .o_word_cnt(wc32), .o_err_cnt(ec32),
    .o_done(dn32), .o_checksum(ck32)
  );

  uart_boot_loader #(.MEM_DW(128), .MEM_AW(11), .CNT_W(16)) u128 (
    .i_clk(clk), .i_rst(rst), .i_byte(byte_d), .i_byte_valid(byte_vld),
    .o_byte_ready(rdy128), .o_wr_valid(wv128), .i_wr_ready(wr_rdy),
    .o_wr_addr(wa128), .o_wr_data(wd128), .o_wr_be(be128),
    .o_line_cnt(lc128), .o_word_cnt(wc128), .o_err_cnt(ec128),
    .o_done(dn128), .o_checksum(ck128)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [10:0] idx32(input logic [31:0] a);
    return 11'((a >> 2) & 32'h7FF);
  endfunction

  function automatic logic [10:0] idx128(input logic [31:0] a);
    return 11'((a >> 4) & 32'h7FF);
  endfunction

  function automatic logic [15:0] bemask128(input logic [31:0] a);
    return 16'(32'hF << (4 * ((a >> 2) & 32'h3)));
  endfunction

  function automatic logic [31:0] exp_ck(input logic [31:0] sum);
`ifdef BOOT_LOADER_CHECKSUM_EN
    return sum;
`else
    return 32'h0 & sum;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    byte_vld = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_d = b;
    byte_vld = 1'b1;
    for (int t = 0; t < 200; t++) begin
      if (rdy32) begin
        tick();
        byte_vld = 1'b0;
        return;
      end
      tick();
    end
    check("send_timeout", 1, 0);
    byte_vld = 1'b0;
  endtask

  task automatic send_str(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) tick();
      send_byte(s[i]);
    end
  endtask

  // Scoreboard: every handshake pops one expected write; stalled payload must hold still.
  logic          stall32_prev = 1'b0, stall128_prev = 1'b0;
  logic [47:0]   prev32;
  logic [154:0]  prev128;
  always @(negedge clk) begin
    if (mon_en) begin
      wr_t e;
      if (stall32_prev) check("stall32", {wa32, wd32, be32}, prev32);
      if (stall128_prev) check("stall128", {wa128, wd128, be128}, prev128);
      if (wv32 && wr_rdy) begin
        if (q32.size() == 0) check("wr32_unexpected", 1, 0);
        else begin
          e = q32.pop_front();
          check("wr32", {wa32, wd32, be32}, {idx32(e.a), e.d, 4'hF});
        end
      end
      if (wv128 && wr_rdy) begin
        if (q128.size() == 0) check("wr128_unexpected", 1, 0);
        else begin
          e = q128.pop_front();
          check("wr128", {wa128, wd128, be128}, {idx128(e.a), {4{e.d}}, bemask128(e.a)});
        end
      end
      stall32_prev  = wv32 && !wr_rdy;
      stall128_prev = wv128 && !wr_rdy;
      prev32  = {wa32, wd32, be32};
      prev128 = {wa128, wd128, be128};
    end else begin
      stall32_prev  = 1'b0;
      stall128_prev = 1'b0;
    end
  end

  initial begin
    logic [31:0] a, am, d, ck_sum;
    int          kind, e_words, e_lines, e_errs;
    string       line, sa, sd;

    vecs[0]  = '{"@00000010 E3A00001\n", 1, 1, 0, 1'b0, 32'hE3A00001};
    vecs[1]  = '{"// hdr\nX12\n@0000001 12345678\n@00000002 11111111\n", 0, 4, 3, 1'b0, 32'h0};
    vecs[2]  = '{"!\n@00000000 00000001\n", 0, 0, 0, 1'b1, 32'h0};
    vecs[3]  = '{"\015 \t\n", 0, 1, 0, 1'b0, 32'h0};
    vecs[4]  = '{"/\n", 0, 1, 1, 1'b0, 32'h0};
    vecs[5]  = '{"@0000000G 11111111\n", 0, 1, 1, 1'b0, 32'h0};
    vecs[6]  = '{"@00000000 123456789\n", 0, 1, 1, 1'b0, 32'h0};
    vecs[7]  = '{"@00000000 12345678/\n", 1, 1, 0, 1'b0, 32'h12345678};
    vecs[8]  = '{"@00000000 FFFFFFFF\n@00000004 00000002\n", 2, 2, 0, 1'b0, 32'h00000001};
    vecs[9]  = '{"@00000008 1\n", 0, 1, 1, 1'b0, 32'h0};
    vecs[10] = '{"@000000040 00000000\n", 0, 1, 1, 1'b0, 32'h0};
    vecs[11] = '{"@00000004 0000000a\015\n", 1, 1, 0, 1'b0, 32'h0000000A};

    // Reset state: everything zero except byte ready.
    do_reset();
    check("rst_rdy", {rdy32, rdy128}, 2'b11);
    check("rst_out32", {wv32, wa32, wd32, be32, lc32, wc32, ec32, dn32, ck32}, 0);
    check("rst_out128", {wv128, wa128, wd128, be128, lc128, wc128, ec128, dn128, ck128}, 0);

    // First write timing and payload, 32-bit and 128-bit lane placement.
    force_rdy = 1'b1;
    send_str("@00000010 E3A00001\n", 0);
    check("lat_valid", {wv32, rdy32, wv128}, 3'b101);
    check("w32_payload", {wa32, wd32, be32}, {11'd4, 32'hE3A00001, 4'hF});
    check("w128_lane0", {wa128, be128, wd128}, {11'd1, 16'h000F, {4{32'hE3A00001}}});
    tick();
    check("w32_after", {wv32, wc32, lc32, ec32}, {1'b0, 16'd1, 16'd1, 16'd0});
    do_reset();
    send_str("@0000001C deadbeef\n", 0);
    check("w128_lane3", {wa128, be128, wd128}, {11'd1, 16'hF000, {4{32'hDEADBEEF}}});
    check("w32_idx7", {wa32, be32, wd32}, {11'd7, 4'hF, 32'hDEADBEEF});
    tick();

    // Directed stream table.
    foreach (vecs[i]) begin
      do_reset();
      force_rdy = 1'b1;
      send_str(vecs[i].txt, 0);
      repeat (3) tick();
      check($sformatf("vec%0d_words", i), wc32, vecs[i].words);
      check($sformatf("vec%0d_lines", i), lc32, vecs[i].lines);
      check($sformatf("vec%0d_errs", i), ec32, vecs[i].errs);
      check($sformatf("vec%0d_done", i), {dn32, dn128}, {2{vecs[i].done}});
      check($sformatf("vec%0d_ck", i), ck32, exp_ck(vecs[i].ck));
      check($sformatf("vec%0d_w128", i), {wc128, ec128}, {16'(vecs[i].words), 16'(vecs[i].errs)});
    end

    // Back-pressure: payload holds, incoming byte waits until after the handshake.
    do_reset();
    force_rdy = 1'b0;
    send_str("@00000008 CAFEF00D\n", 0);
    byte_d = 8'h40;
    byte_vld = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_hold32", {wv32, rdy32, wa32, wd32, be32}, {1'b1, 1'b0, 11'd2, 32'hCAFEF00D, 4'hF});
      check("bp_hold128", {wv128, rdy128, be128}, {1'b1, 1'b0, 16'h0F00});
    end
    force_rdy = 1'b1;
    tick();
    check("bp_handshake", {wv32, rdy32, wc32}, {1'b0, 1'b1, 16'd1});
    tick();
    byte_vld = 1'b0;
    send_str("0000000C 00000003\n", 0);
    check("bp_next_addr", {wv32, wa32, wd32}, {1'b1, 11'd3, 32'h3});
    tick();
    check("bp_counts", {wc32, ec32, lc32}, {16'd2, 16'd0, 16'd2});

    // End marker, then reset while a fresh write is pending.
    do_reset();
    send_str("!\n@00000000 00000001\n", 0);
    tick();
    check("done_set", {dn32, wc32, wv32}, {1'b1, 16'd0, 1'b0});
    force_rdy = 1'b0;
    do_reset();
    check("done_clear", dn32, 0);
    send_str("@00000000 00000001\n", 0);
    check("pend_valid", wv32, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_write", {wv32, rdy32, wc32, dn32, ck32}, {1'b0, 1'b1, 16'd0, 1'b0, 32'h0});
    force_rdy = 1'b1;
    send_str("@00000004 00000005\n", 0);
    tick();
    check("after_rst_write", {wc32, ec32, lc32}, {16'd1, 16'd0, 16'd1});

    // Randomised line mix against the scoreboard, with random stalls and input gaps.
    do_reset();
    rnd_mode = 1'b1;
    mon_en = 1'b1;
    e_words = 0;
    e_lines = 0;
    e_errs = 0;
    ck_sum = 32'h0;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      a = $urandom() & 32'hFFFF_FFFC;
      d = $urandom();
      sa = ($urandom_range(0, 1) != 0) ? $sformatf("%08X", a) : $sformatf("%08x", a);
      sd = ($urandom_range(0, 1) != 0) ? $sformatf("%08X", d) : $sformatf("%08x", d);
      case (kind)
        0: line = {"@", sa, " ", sd, "\n"};
        1: line = {"@", sa, "\t", sd, " // c\n"};
        2: line = {"@", sa, "  ", sd, "\015\n"};
        3: line = "// note\n";
        4: line = " \t\n";
        5: begin
          am = a | 32'($urandom_range(1, 3));
          line = {"@", $sformatf("%08x", am), " ", sd, "\n"};
        end
        6: line = "Zq!\n";
        7: line = {"@", sa, " 1234\n"};
        8: line = "/x\n";
        default: line = {"@", sa, " ", sd, "//x\n"};
      endcase
      e_lines++;
      if (kind <= 2 || kind == 9) begin
        q32.push_back('{a, d});
        q128.push_back('{a, d});
        e_words++;
        ck_sum = ck_sum + d;
      end else if (kind >= 5 && kind <= 8) begin
        e_errs++;
      end
      send_str(line, 1);
    end
    send_str("!\n@00000000 00000009\n", 1);
    repeat (5) tick();
    check("rnd_q_empty", {q32.size(), q128.size()}, 0);
    check("rnd_words", {wc32, wc128}, {16'(e_words), 16'(e_words)});
    check("rnd_lines", {lc32, lc128}, {16'(e_lines), 16'(e_lines)});
    check("rnd_errs", {ec32, ec128}, {16'(e_errs), 16'(e_errs)});
    check("rnd_done", {dn32, dn128}, 2'b11);
    check("rnd_ck", {ck32, ck128}, {exp_ck(ck_sum), exp_ck(ck_sum)});
    mon_en = 1'b0;
    rnd_mode = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
